router_pkt_tx: RTL and testbench



---
 rtl/router_pkg.sv | 25 ++
 rtl/router_tx_buf.sv | 60 ++++++
 rtl/router_pkt_tx.sv | 188 ++++++++++++++++++
 tb/tb_router_pkt_tx.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types and constants for the router packet transmitter: FSM state
// encoding, header field layout and the header packing helper.
package router_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_PARITY,
    ST_GAP
  } tx_state_e;

  localparam int HDR_ADDR_W = 2;
  localparam int HDR_LEN_W  = 6;

  localparam logic [HDR_ADDR_W-1:0] DEST_INVALID = 2'b11;
  localparam logic [HDR_LEN_W-1:0]  MAX_LEN      = 6'd63;

  // Header byte layout: length in [7:2], destination in [1:0].
  function automatic logic [7:0] make_header(input logic [HDR_ADDR_W-1:0] dest,
                                             input logic [HDR_LEN_W-1:0]  len);
    return {len, dest};
  endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Circular payload byte FIFO with a combinational head read. Count is the
// pointer difference with the full flag as its top bit.
module router_tx_buf #(
  parameter int BUF_DEPTH = 64,
  parameter int PTR_W     = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_push,
  input  logic [7:0]     i_push_data,
  input  logic           i_pop,
  output logic [7:0]     o_head,
  output logic           o_full,
  output logic [PTR_W:0] o_count
);

  logic [7:0]       r_mem [BUF_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic             r_full;

  logic             w_empty;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic [PTR_W-1:0] w_wr_ptr_inc;

  assign w_empty      = !r_full && (r_wr_ptr == r_rd_ptr);
  assign w_push_ok    = i_push && !r_full;
  assign w_pop_ok     = i_pop && !w_empty;
  assign w_wr_ptr_inc = r_wr_ptr + 1'b1;

  // NOTE: the storage array is deliberately not reset; the pointers alone define
  // which entries are valid, and leaving it unreset lets it map to plain RAM.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_full   <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= w_wr_ptr_inc;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push_ok && !w_pop_ok && (w_wr_ptr_inc == r_rd_ptr)) begin
        r_full <= 1'b1;
      end else if (w_pop_ok && !w_push_ok) begin
        r_full <= 1'b0;
      end
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_count = {r_full, r_wr_ptr - r_rd_ptr};

endmodule

// File: rtl/router_pkt_tx.sv
// Router ingress packet transmitter: header, payload from the host buffer, then parity.
// Optional ROUTER_TX_PARITY_INJ_EN adds inj_err to send an inverted parity byte.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int BUF_DEPTH = 64,
  parameter int PTR_W     = 6
) (
  input  logic           clk,
  input  logic           rst,
`ifdef ROUTER_TX_PARITY_INJ_EN
  input  logic           inj_err,
`endif
  input  logic           host_wr,
  input  logic [7:0]     host_data,
  output logic           buf_full,
  output logic [PTR_W:0] buf_count,
  input  logic           send,
  input  logic [1:0]     send_dest,
  input  logic [5:0]     send_len,
  output logic           send_ack,
  output logic           send_rej,
  output logic           tx_active,
  output logic           done,
  input  logic           router_busy,
  output logic           pkt_valid,
  output logic [7:0]     pkt_data
);

  tx_state_e            r_state;
  logic [7:0]           r_pkt_data;
  logic                 r_pkt_valid;
  logic [7:0]           r_parity;
  logic [HDR_LEN_W-1:0] r_len;
  logic [HDR_LEN_W-1:0] r_remain;
  logic                 r_send_ack;
  logic                 r_send_rej;
  logic                 r_done;

  tx_state_e            w_state_nxt;
  logic [7:0]           w_data_nxt;
  logic                 w_valid_nxt;
  logic [7:0]           w_parity_nxt;
  logic [HDR_LEN_W-1:0] w_len_nxt;
  logic [HDR_LEN_W-1:0] w_remain_nxt;
  logic                 w_ack_nxt;
  logic                 w_rej_nxt;
  logic                 w_done_nxt;
  logic                 w_pop;
  logic                 w_cmd_ok;
  logic                 w_start;
  logic [7:0]           w_head;
  logic [7:0]           w_par_out;

  router_tx_buf #(
    .BUF_DEPTH(BUF_DEPTH),
    .PTR_W    (PTR_W)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .i_push     (host_wr),
    .i_push_data(host_data),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_full     (buf_full),
    .o_count    (buf_count)
  );

  assign w_cmd_ok = (send_dest != DEST_INVALID) && (send_len != '0) &&
                    (buf_count >= {{(PTR_W+1-HDR_LEN_W){1'b0}}, send_len});
  assign w_start  = (r_state == ST_IDLE) && send && w_cmd_ok;

`ifdef ROUTER_TX_PARITY_INJ_EN
  logic r_inj;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inj <= 1'b0;
    end else if (w_start) begin
      r_inj <= inj_err;
    end
  end

  assign w_par_out = r_parity ^ {8{r_inj}};
`else
  assign w_par_out = r_parity;
`endif

  // NOTE: every combinational output is given its hold/default value first so
  // that no path through the case leaves a signal unassigned (no latches).
  always_comb begin
    w_state_nxt  = r_state;
    w_data_nxt   = r_pkt_data;
    w_valid_nxt  = r_pkt_valid;
    w_parity_nxt = r_parity;
    w_len_nxt    = r_len;
    w_remain_nxt = r_remain;
    w_ack_nxt    = 1'b0;
    w_rej_nxt    = 1'b0;
    w_done_nxt   = 1'b0;
    w_pop        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt  = ST_HEADER;
          w_len_nxt    = send_len;
          w_data_nxt   = make_header(send_dest, send_len);
          w_parity_nxt = make_header(send_dest, send_len);
          w_valid_nxt  = 1'b1;
          w_ack_nxt    = 1'b1;
        end else if (send) begin
          w_rej_nxt = 1'b1;
        end
      end
      ST_HEADER: begin
        if (!router_busy) begin
          w_state_nxt  = ST_PAYLOAD;
          w_pop        = 1'b1;
          w_data_nxt   = w_head;
          w_parity_nxt = r_parity ^ w_head;
          w_remain_nxt = r_len - 1'b1;
        end
      end
      ST_PAYLOAD: begin
        if (!router_busy) begin
          if (r_remain != '0) begin
            w_pop        = 1'b1;
            w_data_nxt   = w_head;
            w_parity_nxt = r_parity ^ w_head;
            w_remain_nxt = r_remain - 1'b1;
          end else begin
            // Running parity already covers the last payload byte here.
            w_state_nxt = ST_PARITY;
            w_data_nxt  = w_par_out;
            w_valid_nxt = 1'b0;
          end
        end
      end
      ST_PARITY: begin
        if (!router_busy) begin
          w_state_nxt = ST_GAP;
          w_done_nxt  = 1'b1;
          w_valid_nxt = 1'b0;
        end
      end
      ST_GAP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_pkt_data  <= '0;
      r_pkt_valid <= 1'b0;
      r_parity    <= '0;
      r_len       <= '0;
      r_remain    <= '0;
      r_send_ack  <= 1'b0;
      r_send_rej  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pkt_data  <= w_data_nxt;
      r_pkt_valid <= w_valid_nxt;
      r_parity    <= w_parity_nxt;
      r_len       <= w_len_nxt;
      r_remain    <= w_remain_nxt;
      r_send_ack  <= w_ack_nxt;
      r_send_rej  <= w_rej_nxt;
      r_done      <= w_done_nxt;
    end
  end

  assign send_ack  = r_send_ack;
  assign send_rej  = r_send_rej;
  assign done      = r_done;
  assign tx_active = (r_state != ST_IDLE);
  assign pkt_valid = r_pkt_valid;
  assign pkt_data  = r_pkt_data;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed self-checking bench for router_pkt_tx: nominal packet, stalls,
// rejections, full-buffer wrap, mid-packet reset and optional parity injection.
module tb_router_pkt_tx;

  logic       clk;
  logic       rst;
  logic       host_wr;
  logic [7:0] host_data;
  logic       buf_full;
  logic [6:0] buf_count;
  logic       send;
  logic [1:0] send_dest;
  logic [5:0] send_len;
  logic       send_ack;
  logic       send_rej;
  logic       tx_active;
  logic       done;
  logic       router_busy;
  logic       pkt_valid;
  logic [7:0] pkt_data;
  logic       inj_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int cyc_send = 0;
  logic [7:0] exp_par;
  logic [7:0] inj_mask;

  router_pkt_tx #(.BUF_DEPTH(64), .PTR_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef ROUTER_TX_PARITY_INJ_EN
    .inj_err    (inj_err),
`endif
    .host_wr    (host_wr),
    .host_data  (host_data),
    .buf_full   (buf_full),
    .buf_count  (buf_count),
    .send       (send),
    .send_dest  (send_dest),
    .send_len   (send_len),
    .send_ack   (send_ack),
    .send_rej   (send_rej),
    .tx_active  (tx_active),
    .done       (done),
    .router_busy(router_busy),
    .pkt_valid  (pkt_valid),
    .pkt_data   (pkt_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input logic [7:0] b);
    host_wr   = 1'b1;
    host_data = b;
    tick();
    host_wr   = 1'b0;
  endtask

  task automatic issue(input logic [1:0] dest, input logic [5:0] len);
    send      = 1'b1;
    send_dest = dest;
    send_len  = len;
    tick();
    send      = 1'b0;
    cyc_send  = cyc;
  endtask

  task automatic bus(input string tag, input logic [7:0] d, input logic v);
    check({tag, "_data"}, pkt_data, d);
    check({tag, "_valid"}, pkt_valid, v);
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!done && k < 200) begin
      tick();
      k++;
    end
    check(tag, done, 1'b1);
  endtask

  initial begin
    rst = 1'b1; host_wr = 1'b0; host_data = '0; send = 1'b0; send_dest = '0;
    send_len = '0; router_busy = 1'b0; inj_err = 1'b0;
`ifdef ROUTER_TX_PARITY_INJ_EN
    inj_mask = 8'hFF;
`else
    inj_mask = 8'h00;
`endif
    tick(); tick();
    rst = 1'b0;
    check("rst_valid", pkt_valid, 1'b0);
    check("rst_data", pkt_data, 8'h00);
    check("rst_active", tx_active, 1'b0);
    check("rst_count", buf_count, 7'd0);
    check("rst_full", buf_full, 1'b0);
    check("rst_ack", send_ack, 1'b0);
    check("rst_done", done, 1'b0);

    // Nominal packet: dest 1, len 3 -> header 0x0D.
    push(8'hA1); push(8'hB2); push(8'hC3);
    check("t1_count3", buf_count, 7'd3);
    issue(2'd1, 6'd3);
    check("t1_ack", send_ack, 1'b1);
    check("t1_active", tx_active, 1'b1);
    bus("t1_hdr", 8'h0D, 1'b1);
    tick(); bus("t1_p0", 8'hA1, 1'b1);
    check("t1_ack_pulse", send_ack, 1'b0);
    tick(); bus("t1_p1", 8'hB2, 1'b1);
    tick(); bus("t1_p2", 8'hC3, 1'b1);
    check("t1_count0", buf_count, 7'd0);
    tick(); bus("t1_par", 8'h0D ^ 8'hA1 ^ 8'hB2 ^ 8'hC3, 1'b0);
    wait_done("t1_done");
    check("t1_latency", cyc - cyc_send, 5);
    bus("t1_hold", 8'h0D ^ 8'hA1 ^ 8'hB2 ^ 8'hC3, 1'b0);
    check("t1_gap_active", tx_active, 1'b1);
    tick();
    check("t1_done_pulse", done, 1'b0);
    check("t1_idle", tx_active, 1'b0);

    // Same packet with 2 stall cycles on the header and 3 mid-payload.
    push(8'hA1); push(8'hB2); push(8'hC3);
    issue(2'd1, 6'd3);
    bus("t2_hdr", 8'h0D, 1'b1);
    router_busy = 1'b1;
    tick(); bus("t2_hdr_s1", 8'h0D, 1'b1);
    tick(); bus("t2_hdr_s2", 8'h0D, 1'b1);
    router_busy = 1'b0;
    tick(); bus("t2_p0", 8'hA1, 1'b1);
    tick(); bus("t2_p1", 8'hB2, 1'b1);
    router_busy = 1'b1;
    tick(); bus("t2_p1_s1", 8'hB2, 1'b1);
    tick(); bus("t2_p1_s2", 8'hB2, 1'b1);
    tick(); bus("t2_p1_s3", 8'hB2, 1'b1);
    router_busy = 1'b0;
    tick(); bus("t2_p2", 8'hC3, 1'b1);
    tick(); bus("t2_par", 8'h0D ^ 8'hA1 ^ 8'hB2 ^ 8'hC3, 1'b0);
    wait_done("t2_done");
    check("t2_latency", cyc - cyc_send, 10);
    tick();

    // Rejections with 4 bytes held.
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    issue(2'd3, 6'd1);
    check("t3_rej_dest", send_rej, 1'b1);
    check("t3_rej_dest_ack", send_ack, 1'b0);
    check("t3_rej_dest_active", tx_active, 1'b0);
    check("t3_rej_dest_count", buf_count, 7'd4);
    tick();
    check("t3_rej_pulse", send_rej, 1'b0);
    issue(2'd0, 6'd0);
    check("t3_rej_len0", send_rej, 1'b1);
    check("t3_rej_len0_active", tx_active, 1'b0);
    check("t3_rej_len0_count", buf_count, 7'd4);
    tick();
    issue(2'd2, 6'd5);
    check("t3_rej_short", send_rej, 1'b1);
    check("t3_rej_short_active", tx_active, 1'b0);
    check("t3_rej_short_count", buf_count, 7'd4);
    tick();

    // Exact-fit send (dest 2, len 4 -> header 0x12); a send mid-packet is ignored.
    issue(2'd2, 6'd4);
    check("t3_ack", send_ack, 1'b1);
    bus("t3_hdr", 8'h12, 1'b1);
    send = 1'b1; send_dest = 2'd0; send_len = 6'd1;
    tick();
    send = 1'b0;
    check("t3_busy_send_ack", send_ack, 1'b0);
    check("t3_busy_send_rej", send_rej, 1'b0);
    bus("t3_p0", 8'h11, 1'b1);
    tick(); bus("t3_p1", 8'h22, 1'b1);
    tick(); bus("t3_p2", 8'h33, 1'b1);
    tick(); bus("t3_p3", 8'h44, 1'b1);
    tick(); bus("t3_par", 8'h12 ^ 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44, 1'b0);
    wait_done("t3_done");
    tick();

    // Fill to 64, drop a 65th write, then send 63 across the pointer wrap.
    for (int i = 0; i < 64; i++) begin
      host_wr = 1'b1; host_data = 8'(i);
      tick();
    end
    check("t4_full", buf_full, 1'b1);
    check("t4_count64", buf_count, 7'd64);
    host_data = 8'hEE;
    tick();
    host_wr = 1'b0;
    check("t4_drop_count", buf_count, 7'd64);
    check("t4_drop_full", buf_full, 1'b1);
    issue(2'd0, 6'd63);
    bus("t4_hdr", 8'hFC, 1'b1);
    exp_par = 8'hFC;
    for (int i = 0; i < 63; i++) begin
      tick();
      bus($sformatf("t4_p%0d", i), 8'(i), 1'b1);
      exp_par = exp_par ^ 8'(i);
    end
    tick(); bus("t4_par", exp_par, 1'b0);
    wait_done("t4_done");
    check("t4_count1", buf_count, 7'd1);
    tick();

    // Leftover byte 0x3F leads; simultaneous push/pop; then reset mid-payload.
    push(8'h5A); push(8'h6B); push(8'h7C);
    issue(2'd1, 6'd3);
    bus("t5_hdr", 8'h0D, 1'b1);
    host_wr = 1'b1; host_data = 8'h55;
    tick();
    host_wr = 1'b0;
    bus("t5_p0", 8'h3F, 1'b1);
    check("t5_pushpop_count", buf_count, 7'd4);
    tick(); bus("t5_p1", 8'h5A, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_rst_valid", pkt_valid, 1'b0);
    check("t5_rst_active", tx_active, 1'b0);
    check("t5_rst_count", buf_count, 7'd0);
    check("t5_rst_data", pkt_data, 8'h00);

    // Fresh packet after reset (parity inverted when injection is built in).
    push(8'hA1); push(8'hB2); push(8'hC3);
    inj_err = 1'b1;
    issue(2'd1, 6'd3);
    inj_err = 1'b0;
    check("t6_ack", send_ack, 1'b1);
    bus("t6_hdr", 8'h0D, 1'b1);
    tick(); bus("t6_p0", 8'hA1, 1'b1);
    tick(); bus("t6_p1", 8'hB2, 1'b1);
    tick(); bus("t6_p2", 8'hC3, 1'b1);
    tick(); bus("t6_par", (8'h0D ^ 8'hA1 ^ 8'hB2 ^ 8'hC3) ^ inj_mask, 1'b0);
    wait_done("t6_done");
    tick();
    check("t6_idle", tx_active, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
